demux1to3_stream: RTL and testbench

- Registered 1-to-3 demultiplexer with a valid/ready handshake; the inverse of the team's 3:1 mux.
- Accepts one WIDTH-bit word per transfer and steers it to output lane 0, 1 or 2 according to select.
- Each lane has a one-entry output register, so a stalled lane blocks only words destined for it.
- Illegal select code 2'b11 is consumed, discarded, flagged and counted. The combinational mux treats that code as 1'bx.

---
 rtl/demux_pkg.sv | 10 +
 rtl/demux1to3_stream_lane_reg.sv | 30 +++
 rtl/demux1to3_stream.sv | 70 +++++++
 tb/tb_demux1to3_stream.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared select codes and lane count for the 1-to-3 stream demux
package demux_pkg;

   localparam logic [1:0] LANE0       = 2'b00;
   localparam logic [1:0] LANE1       = 2'b01;
   localparam logic [1:0] LANE2       = 2'b10;
   localparam logic [1:0] SEL_ILLEGAL = 2'b11;
   localparam int         NLANES      = 3;

endpackage

// File: rtl/demux1to3_stream_lane_reg.sv
// rtl/demux1to3_stream_lane_reg.sv - one-entry valid/ready output register for a single lane
module lane_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] q,
   output logic             free
);

   // The top only asserts load when free is high, so a load never overwrites a held word.
   assign free = !valid || ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux1to3_stream.sv
// rtl/demux1to3_stream.sv - registered 1-to-3 valid/ready demux with illegal-select drop counting
module demux1to3_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              select,
   input  logic [WIDTH-1:0]        d,
   output logic [NLANES-1:0]       q_valid,
   input  logic [NLANES-1:0]       q_ready,
   output logic [NLANES*WIDTH-1:0] q,
   output logic                    err,
   output logic [CNT_W-1:0]        drop_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [NLANES-1:0] lane_free;
   logic [NLANES-1:0] load;
   logic              sel_free;
   logic              accept;
   logic              drop;

   always_comb begin
      sel_free = 1'b1;
      case (select)
         LANE0:   sel_free = lane_free[0];
         LANE1:   sel_free = lane_free[1];
         LANE2:   sel_free = lane_free[2];
         default: sel_free = 1'b1;
      endcase
   end

   assign in_ready = !reset && sel_free;
   assign accept   = in_valid && in_ready;
   assign drop     = accept && (select == SEL_ILLEGAL);

   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      assign load[i] = accept && (select == 2'(i));

      lane_reg #(.WIDTH(WIDTH)) u_lane (
         .clk   (clk),
         .reset (reset),
         .load  (load[i]),
         .d     (d),
         .ready (q_ready[i]),
         .valid (q_valid[i]),
         .q     (q[i*WIDTH +: WIDTH]),
         .free  (lane_free[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err        <= 1'b0;
         drop_count <= '0;
      end else begin
         err <= drop;
         if (drop && drop_count != CNT_MAX) begin
            drop_count <= drop_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_demux1to3_stream.sv
// tb/tb_demux1to3_stream.sv - scoreboard bench for demux1to3_stream with per-lane expected queues
module tb_demux1to3_stream;

   localparam int WIDTH   = 8;
   localparam int CNT_W   = 8;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         select;
   logic [WIDTH-1:0]   d;
   logic [2:0]         q_valid;
   logic [2:0]         q_ready;
   logic [3*WIDTH-1:0] q;
   logic               err;
   logic [CNT_W-1:0]   drop_count;

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_en   = 1'b0;

   logic [WIDTH-1:0] lane_q[3][$];
   bit               exp_err = 1'b0;
   int               exp_cnt = 0;

   demux1to3_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .select     (select),
      .d          (d),
      .q_valid    (q_valid),
      .q_ready    (q_ready),
      .q          (q),
      .err        (err),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   task automatic drive(input bit v, input logic [1:0] sel, input logic [WIDTH-1:0] data,
                        input logic [2:0] qr, input bit rst);
      @(posedge clk);
      #1;
      in_valid = v;
      select   = sel;
      d        = data;
      q_ready  = qr;
      reset    = rst;
   endtask

   // Monitor: compare against the queues, then apply what the coming edge will do.
   always @(negedge clk) begin
      if (mon_en) begin
         logic       exp_rdy;
         logic [2:0] exp_qv;
         exp_rdy = reset ? 1'b0 :
                   (select == 2'b11) ? 1'b1 :
                   (lane_q[select].size() == 0 || q_ready[select]);
         for (int i = 0; i < 3; i++) exp_qv[i] = (lane_q[i].size() != 0);
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
         chk("q_valid", 32'(q_valid), 32'(exp_qv));
         for (int i = 0; i < 3; i++)
            if (lane_q[i].size() != 0)
               chk($sformatf("lane%0d_data", i), 32'(q[i*WIDTH +: WIDTH]), 32'(lane_q[i][0]));
         chk("err", 32'(err), 32'(exp_err));
         chk("drop_count", 32'(drop_count), 32'(exp_cnt));

         if (reset) begin
            for (int i = 0; i < 3; i++) lane_q[i].delete();
            exp_err = 1'b0;
            exp_cnt = 0;
         end else begin
            for (int i = 0; i < 3; i++)
               if (lane_q[i].size() != 0 && q_ready[i]) void'(lane_q[i].pop_front());
            exp_err = 1'b0;
            if (in_valid && exp_rdy) begin
               if (select == 2'b11) begin
                  exp_err = 1'b1;
                  if (exp_cnt < CNT_SAT) exp_cnt++;
               end else begin
                  lane_q[select].push_back(d);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit held;
      reset = 1'b1; in_valid = 1'b0; select = 2'b00; d = '0; q_ready = 3'b000;
      @(posedge clk);
      mon_en = 1'b1;
      drive(0, 2'b00, 8'h00, 3'b111, 1);

      // Single word to lane1.
      drive(1, 2'b01, 8'hA5, 3'b111, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);

      // Stall lane0, side word to lane2, then release lane0.
      drive(1, 2'b00, 8'h11, 3'b000, 0);
      drive(1, 2'b00, 8'h22, 3'b000, 0);
      drive(1, 2'b00, 8'h22, 3'b000, 0);
      drive(0, 2'b00, 8'h00, 3'b000, 0);
      drive(1, 2'b10, 8'h33, 3'b000, 0);
      drive(1, 2'b00, 8'h22, 3'b000, 0);
      drive(1, 2'b00, 8'h22, 3'b001, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);

      // Streaming into lane0.
      for (int k = 1; k <= 4; k++) drive(1, 2'b00, 8'(k), 3'b111, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);

      // Back-to-back illegal words.
      for (int k = 0; k < 3; k++) drive(1, 2'b11, 8'hFF, 3'b111, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);

      // Reset mid-stall with lanes 0 and 2 holding, then a fresh accept.
      drive(1, 2'b00, 8'h44, 3'b000, 0);
      drive(1, 2'b10, 8'h55, 3'b000, 0);
      drive(0, 2'b00, 8'h00, 3'b000, 1);
      drive(1, 2'b10, 8'h66, 3'b000, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);

      // Drive the drop counter into saturation.
      for (int k = 0; k < CNT_SAT + 5; k++) drive(1, 2'b11, 8'(k), 3'b111, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 1);

      // Random traffic with the upstream hold rule respected.
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         held = in_valid && !in_ready;
         @(posedge clk);
         #1;
         reset   = ($urandom_range(0, 149) == 0);
         q_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0)};
         if (!held) begin
            in_valid = ($urandom_range(0, 3) != 0);
            select   = 2'($urandom_range(0, 3));
            d        = 8'($urandom);
         end
      end
      drive(0, 2'b00, 8'h00, 3'b111, 0);
      drive(0, 2'b00, 8'h00, 3'b111, 0);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
